// File: rtl/dm_bytelane.sv
// dm_bytelane: word-organised MEM-stage data memory with byte-lane stores and sign/zero-extended sub-word loads.
// Latency: one cycle; a request accepted at edge N gives o_rsp_valid for the cycle that follows.
// Backpressure: o_req_ready is low while the post-reset clear sweep runs; in RUN it accepts one request per cycle.
//
// Ports:
//   i_clk, i_reset         clock; synchronous active-high reset
//   i_req_valid/o_req_ready request handshake
//   i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata, i_req_pc   request fields
//   o_rsp_valid, o_rsp_rdata, o_rsp_err                                       registered response
//   o_busy                 clear sweep in progress
// Optional feature macro: DM_TRACE_EN (prints a write trace line for each successful store).

module dm_bytelane #(
    parameter int ADDR_W = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [31:0] i_req_pc,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;

    logic [31:0]         r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_idx;
    logic [1:0]          w_lane;
    logic                w_err;
    logic                w_accept;
    logic [31:0]         w_old;
    logic [3:0]          w_st_be;
    logic [31:0]         w_st_dat;
    logic [31:0]         w_merged;
    logic [7:0]          w_ld_byte;
    logic [15:0]         w_ld_half;
    logic [31:0]         w_ld_data;

    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_idx;
    logic [3:0]          w_wr_be;
    logic [31:0]         w_wr_dat;

    // ---------------------------------------------------------------
    // FSM: state register and clear pointer
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        o_busy      = 1'b0;
        o_req_ready = 1'b0;
        case (r_state)
            S_CLEAR: begin
                o_busy    = 1'b1;
                w_ptr_nxt = r_ptr + 1'b1;
                // The edge that zeroes the last word hands over to RUN.
                if (r_ptr == '1) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_req_ready = 1'b1;
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    assign w_idx    = i_req_addr[ADDR_W+1:2];
    assign w_lane   = i_req_addr[1:0];
    assign w_accept = i_req_valid & o_req_ready & ~i_reset;
    assign w_old    = r_mem[w_idx];

    always_comb begin
        w_err = 1'b0;
        case (i_req_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = i_req_addr[0];
            2'b10:   w_err = (i_req_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
        // Any address bit above the array span is out of range.
        if (|i_req_addr[31:ADDR_W+2]) begin
            w_err = 1'b1;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick placement.
    always_comb begin
        w_st_be  = 4'b0000;
        w_st_dat = i_req_wdata;
        case (i_req_size)
            2'b00: begin
                w_st_be  = 4'b0001 << w_lane;
                w_st_dat = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be  = i_req_addr[1] ? 4'b1100 : 4'b0011;
                w_st_dat = {2{i_req_wdata[15:0]}};
            end
            2'b10: begin
                w_st_be  = 4'b1111;
                w_st_dat = i_req_wdata;
            end
            default: begin
                w_st_be  = 4'b0000;
                w_st_dat = i_req_wdata;
            end
        endcase
    end

    always_comb begin
        w_merged = w_old;
        for (int k = 0; k < 4; k++) begin
            if (w_st_be[k]) begin
                w_merged[8*k +: 8] = w_st_dat[8*k +: 8];
            end
        end
    end

    // Load lane selection and extension (little-endian lanes).
    assign w_ld_byte = w_old[{w_lane, 3'b000} +: 8];
    assign w_ld_half = i_req_addr[1] ? w_old[31:16] : w_old[15:0];

    always_comb begin
        w_ld_data = w_old;
        case (i_req_size)
            2'b00:   w_ld_data = {{24{~i_req_unsigned & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_data = {{16{~i_req_unsigned & w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = w_old;
        endcase
    end

    // ---------------------------------------------------------------
    // Single array write port shared by the clear sweep and stores
    // ---------------------------------------------------------------
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = w_idx;
        w_wr_be  = w_st_be;
        w_wr_dat = w_st_dat;
        if (r_state == S_CLEAR) begin
            w_wr_en  = ~i_reset;
            w_wr_idx = r_ptr;
            w_wr_be  = 4'b1111;
            w_wr_dat = 32'h0000_0000;
        end else begin
            w_wr_en  = w_accept & i_req_we & ~w_err;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_be[k]) begin
                    r_mem[w_wr_idx][8*k +: 8] <= w_wr_dat[8*k +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Registered response; reset drops anything in flight
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= 32'h0000_0000;
        end else begin
            o_rsp_valid <= w_accept;
            o_rsp_err   <= w_accept & w_err;
            o_rsp_rdata <= (w_accept & ~i_req_we & ~w_err) ? w_ld_data : 32'h0000_0000;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge i_clk) begin
        if (w_accept & i_req_we & ~w_err) begin
            $display("@%h: *%h <= %h", i_req_pc, {i_req_addr[31:2], 2'b00}, w_merged);
        end
    end
`else
    // The PC and merged word only feed the trace.
    logic w_unused_trace;
    assign w_unused_trace = ^{i_req_pc, w_merged};
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
module tb_dm_bytelane;

    localparam int AW = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    dm_bytelane #(.ADDR_W(AW)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .i_req_pc       (req_pc),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_pc       = 32'h0040_0000 + addr;
    endtask

    // Holds reset for one edge, then checks 16 busy cycles and ready afterwards.
    task automatic sweep_check(input string tag, input logic hold_load);
        if (hold_load) drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        else req_valid = 1'b0;
        reset = 1'b1;
        step();
        chk({tag, "_rst_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rst_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rst_err"},   {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("%s_busy%0d", tag, c),  {31'd0, busy}, 32'd1);
            chk($sformatf("%s_rdy%0d", tag, c),   {31'd0, req_ready}, 32'd0);
            chk($sformatf("%s_nvld%0d", tag, c),  {31'd0, rsp_valid}, 32'd0);
            step();
        end
        chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_busy_after"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_pc       = 32'h0;

        //            we    size   uns   addr   wdata          err   rdata
        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h8,  32'h11223344, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 2'b00, 1'b0, 32'h9,  32'hFFFFFFAA, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 2'b01, 1'b0, 32'hA,  32'h7777BEEF, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, 32'h8,  32'h0,        1'b0, 32'hBEEFAA44};
        tbl[4]  = '{1'b0, 2'b00, 1'b0, 32'hB,  32'h0,        1'b0, 32'hFFFFFFBE};
        tbl[5]  = '{1'b0, 2'b00, 1'b1, 32'hB,  32'h0,        1'b0, 32'h000000BE};
        tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'hA,  32'h0,        1'b0, 32'hFFFFBEEF};
        tbl[7]  = '{1'b0, 2'b01, 1'b1, 32'h8,  32'h0,        1'b0, 32'h0000AA44};
        tbl[8]  = '{1'b0, 2'b00, 1'b0, 32'h8,  32'h0,        1'b0, 32'h00000044};
        tbl[9]  = '{1'b0, 2'b10, 1'b1, 32'h8,  32'h0,        1'b0, 32'hBEEFAA44};
        tbl[10] = '{1'b1, 2'b10, 1'b0, 32'h6,  32'hDEADBEEF, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 2'b01, 1'b0, 32'h3,  32'h0,        1'b1, 32'h0};
        tbl[12] = '{1'b0, 2'b11, 1'b0, 32'h8,  32'h0,        1'b1, 32'h0};
        tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        1'b1, 32'h0};
        tbl[14] = '{1'b1, 2'b00, 1'b0, 32'h40, 32'h55,       1'b1, 32'h0};
        tbl[15] = '{1'b0, 2'b10, 1'b0, 32'h8,  32'h0,        1'b0, 32'hBEEFAA44};
        tbl[16] = '{1'b0, 2'b10, 1'b0, 32'h4,  32'h0,        1'b0, 32'h0};
        tbl[17] = '{1'b1, 2'b10, 1'b0, 32'h4,  32'hCAFEF00D, 1'b0, 32'h0};
        tbl[18] = '{1'b0, 2'b10, 1'b0, 32'h4,  32'h0,        1'b0, 32'hCAFEF00D};
        tbl[19] = '{1'b0, 2'b10, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};

        @(negedge clk);
        @(negedge clk);

        // Clear sweep with a load held on the port throughout.
        sweep_check("clr", 1'b1);
        step();
        chk("first_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("first_rsp_rdata", rsp_rdata, 32'h0);
        chk("first_rsp_err",   {31'd0, rsp_err}, 32'd0);

        // Table vectors issued back-to-back, one per cycle.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata);
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("v%0d_err", i),   {31'd0, rsp_err}, {31'd0, tbl[i].err});
            chk($sformatf("v%0d_rdata", i), rsp_rdata, tbl[i].rdata);
        end
        req_valid = 1'b0;
        step();
        chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_rdata", rsp_rdata, 32'd0);

        // Store, then reset while its response is still pending.
        drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678);
        step();
        chk("st0_valid", {31'd0, rsp_valid}, 32'd1);
        req_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("pend_drop_valid", {31'd0, rsp_valid}, 32'd0);
        chk("pend_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        // Four sweep edges, then reset lands on the fifth.
        for (int c = 0; c < 4; c++) step();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        sweep_check("mid", 1'b0);

        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
        req_valid = 1'b0;
        chk("post_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_rdata", rsp_rdata, 32'h0);
        chk("post_err",   {31'd0, rsp_err}, 32'd0);
        step();
        chk("post_idle",  {31'd0, rsp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_bytelane.md
# dm_bytelane

Parametrised word-organised data memory for the pipelined MIPS core, sitting in the MEM stage. Supports byte, halfword and word stores through byte-lane enables, and sign- or zero-extended sub-word loads. Uses a valid/ready request port with a registered one-cycle response. On reset it runs a hardware clear sweep that zeroes the array one word per cycle, so there is no single-cycle reset of the whole array.

## Interface
- `ADDR_W`, default 10, word-index width; depth = 2^ADDR_W words of 32 bits.
- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  load zero-extends (lbu/lhu) when 1, sign-extends when 0.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_pc`  in  32  PC of the issuing instruction; used only for trace.
- `rsp_valid`  out  1  response for the request accepted on the previous edge.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned, out of range or illegal size.
- `busy`  out  1  clear sweep in progress.

## Operation
- Two states: CLEAR and RUN, with a clear pointer `ptr` of width ADDR_W.
- Reset high at an edge:
  - state goes to CLEAR, `ptr` goes to 0.
  - `rsp_valid`, `rsp_err` and `rsp_rdata` go to 0.
  - Any in-flight response is dropped.
- CLEAR state:
  - Each edge with reset low writes 0 to word `ptr` and increments `ptr`.
  - The edge that writes word 2^ADDR_W−1 moves the state to RUN.
  - `busy`=1 and `req_ready`=0 throughout.
- RUN state: `busy`=0, `req_ready`=1. A request is accepted at an edge when `req_valid` and `req_ready` are both high.
- Error when any of the following holds:
  - `req_size`=11.
  - half with `req_addr[0]`=1.
  - word with `req_addr[1:0]`≠0.
  - `req_addr[31:ADDR_W+2]`≠0.
- On error: no array write; response is `rsp_err`=1, `rsp_rdata`=0.
- Store: word index is `req_addr[ADDR_W+1:2]`.
  - byte writes lane `addr[1:0]` with `wdata[7:0]`.
  - half writes lanes {2·addr[1]+1, 2·addr[1]} with `wdata[15:0]`.
  - word writes all four lanes.
  - Untouched lanes are preserved.
  - Response: `rsp_err`=0, `rsp_rdata`=0.
- Load: the selected byte or half is taken from the lane(s) above, extended per `req_unsigned`, and registered into `rsp_rdata`. A word load ignores `req_unsigned`.
- Lane order is little-endian: lane 0 is bits [7:0].

## Timing
- Reset values after the reset edge: `req_ready`=0, `busy`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Clear takes exactly 2^ADDR_W edges after reset deasserts. `req_ready` rises after the last of those edges.
- Latency: a request accepted at edge N produces `rsp_valid`=1 for exactly the cycle after N. Edge N+1 clears it unless a new request is accepted at N+1.
- Full throughput: one request per cycle, with no bubbles in RUN.
- Read-after-write: a load accepted at edge N+1 observes a store accepted at edge N, with merged lanes.
- Reset asserted mid-sweep restarts the sweep from `ptr`=0.
- Reset asserted while a response is pending suppresses that response.
- Requests presented while `req_ready`=0 are ignored: not accepted, no response.

## Configuration
- `DM_TRACE_EN` defined: each accepted, non-error store prints `@<req_pc hex>: *<word-aligned addr hex> <= <merged 32-bit word hex>` at the write edge, in the same format as the core's existing write trace.
- `DM_TRACE_EN` undefined: no `$display`, and `req_pc` is unused. Functional behaviour is identical in both cases.

## Test plan
All scenarios use ADDR_W=4 (16 words).
- Clear sweep: assert reset for 1 cycle, hold `req_valid`=1 as a load of addr 0x0.
  - `busy`=1 and `req_ready`=0 for 16 cycles; no `rsp_valid` during the sweep.
  - The first response is `rsp_rdata`=0x00000000.
- Byte/half merge: sw 0x11223344 to 0x8, then sb 0xAA to 0x9, then sh 0xBEEF to 0xA, then lw 0x8.
  - Response is `rsp_rdata`=0xBEEFAA44.
- Extension: after the merge above:
  - lb 0xB gives 0xFFFFFFBE.
  - lbu 0xB gives 0x000000BE.
  - lh 0xA gives 0xFFFFBEEF.
  - lhu 0x8 gives 0x0000AA44.
- Errors, each giving `rsp_err`=1 and `rsp_rdata`=0 with memory unchanged:
  - sw to 0x6.
  - lh at 0x3.
  - size=11.
  - lw 0x40 (out of range).
- Back-to-back RAW: sw 0xCAFEF00D to 0x4 at edge N, lw 0x4 at edge N+1.
  - `rsp_valid`=1 on two consecutive cycles; the second carries 0xCAFEF00D.
- Reset mid-operation: store 0x12345678 to 0x0, then assert reset at the sweep's 5th cycle.
  - The sweep restarts, taking 16 cycles after deassert.
  - lw 0x0 then returns 0.
